// File: rtl/result_stream_packer.sv
// Packs 97-bit hit records four-per-beat into 512-bit AXI4-Stream beats for the
// host DMA. Each start defines one frame of cfg_num_results records.

module result_stream_packer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is legal only when a pop frees the entry this cycle.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for start; no records accepted
// RUN    | accepting, packing and emitting beats of the current frame
// DONE   | one-cycle done pulse after the final beat handshake
module result_stream_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int RESULT_W   = 97,
    parameter int SLOT_W     = 128,
    parameter int BEAT_W     = 512
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic [31:0]           cfg_num_results,
    output logic                  busy,
    output logic                  done,
    output logic                  result_stream_full_n,
    input  logic [RESULT_W-1:0]   result_stream_wr_data,
    input  logic                  result_stream_wr_en,
    output logic [BEAT_W-1:0]     m_axis_tdata,
    output logic [BEAT_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int SLOTS  = BEAT_W / SLOT_W;
    localparam int SLOT_B = SLOT_W / 8;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         num_results;
    logic [31:0]         accepted_cnt;
    logic [31:0]         pack_cnt;
    logic [31:0]         remaining;
    logic [IDX_W-1:0]    slot_idx;
    logic [RESULT_W-1:0] slot_buf [SLOTS];

    logic                start_ok;
    logic                wr_accept;
    logic                fifo_empty;
    logic                fifo_full;
    logic [RESULT_W-1:0] fifo_rd_data;
    logic                out_free;
    logic                pop;
    logic                last_rec;
    logic                beat_close;
    logic [BEAT_W-1:0]   beat_data;
    logic [BEAT_W/8-1:0] beat_keep;

    assign start_ok  = start & (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // full_n is built only from registered state so tready never reaches it.
    assign result_stream_full_n = (state == S_RUN) & ~fifo_full & (accepted_cnt < num_results);
    assign wr_accept = result_stream_wr_en & result_stream_full_n;

    assign out_free   = ~m_axis_tvalid | m_axis_tready;
    assign pop        = (state == S_RUN) & ~fifo_empty & out_free;
    assign remaining  = num_results - pack_cnt;
    assign last_rec   = (remaining == 32'd1);
    assign beat_close = pop & ((slot_idx == LAST_IDX) | last_rec);

    result_stream_packer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RESULT_W)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (start_ok),
        .push      (wr_accept),
        .push_data (result_stream_wr_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Closing beat: earlier slots from the buffer, current slot straight from the FIFO.
    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (k < int'(slot_idx)) begin
                beat_data[k*SLOT_W +: RESULT_W] = slot_buf[k];
            end else if (k == int'(slot_idx)) begin
                beat_data[k*SLOT_W +: RESULT_W] = fifo_rd_data;
            end
            if (k <= int'(slot_idx)) begin
                beat_keep[k*SLOT_B +: SLOT_B] = '1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cfg_num_results == 32'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (m_axis_tvalid & m_axis_tready & m_axis_tlast) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            num_results  <= '0;
            accepted_cnt <= '0;
            pack_cnt     <= '0;
            slot_idx     <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                slot_buf[k] <= '0;
            end
        end else if (start_ok) begin
            num_results  <= cfg_num_results;
            accepted_cnt <= '0;
            pack_cnt     <= '0;
            slot_idx     <= '0;
        end else begin
            if (wr_accept) begin
                accepted_cnt <= accepted_cnt + 32'd1;
            end
            if (pop) begin
                pack_cnt           <= pack_cnt + 32'd1;
                slot_buf[slot_idx] <= fifo_rd_data;
                slot_idx           <= beat_close ? '0 : slot_idx + IDX_W'(1);
            end
        end
    end

    // A closing beat may load on the same cycle the previous beat drains.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
        end else if (beat_close) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_rec;
            m_axis_tdata  <= beat_data;
            m_axis_tkeep  <= beat_keep;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_result_stream_packer.sv
// Bench for result_stream_packer: table of frames plus reset and restart
// sequences, with accepted records queued and checked against each emitted beat.

module tb_result_stream_packer;
    localparam int RW = 97;

    logic          aclk;
    logic          aresetn;
    logic          start;
    logic [31:0]   cfg_n;
    logic          busy;
    logic          done;
    logic          full_n;
    logic [RW-1:0] wr_data;
    logic          wr_en;
    logic [511:0]  tdata;
    logic [63:0]   tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    typedef struct {
        int          n;
        int          stall;
        int          extra;
        int          restart;
        int          exp_beats;
        logic [63:0] exp_last_keep;
    } frame_vec_t;

    int checks = 0;
    int failures = 0;
    logic [RW-1:0] exp_q [$];
    frame_vec_t vecs [8];

    result_stream_packer dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .start                 (start),
        .cfg_num_results       (cfg_n),
        .busy                  (busy),
        .done                  (done),
        .result_stream_full_n  (full_n),
        .result_stream_wr_data (wr_data),
        .result_stream_wr_en   (wr_en),
        .m_axis_tdata          (tdata),
        .m_axis_tkeep          (tkeep),
        .m_axis_tlast          (tlast),
        .m_axis_tvalid         (tvalid),
        .m_axis_tready         (tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic string nm(input int fi, input string s);
        return $sformatf("f%0d_%s", fi, s);
    endfunction

    function automatic logic [RW-1:0] rand_rec();
        return {$urandom(), $urandom(), $urandom(), 1'($urandom())};
    endfunction

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_frame(input int fi, input frame_vec_t v);
        int hs_cyc;
        int beats;
        int rcv;
        logic got_done;
        logic [63:0] last_keep;
        hs_cyc = -1;
        beats = 0;
        rcv = 0;
        got_done = 1'b0;
        last_keep = '0;
        exp_q.delete();
        @(negedge aclk);
        cfg_n = v.n;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        chk1(nm(fi, "busy_after_start"), busy, 1'b1);
        fork
            begin : producer
                int sent;
                int pcyc;
                sent = 0;
                pcyc = 0;
                while (sent < v.n && pcyc < 2000) begin
                    wr_en = 1'b1;
                    wr_data = rand_rec();
                    if (full_n) begin
                        exp_q.push_back(wr_data);
                        sent++;
                    end
                    @(negedge aclk);
                    pcyc++;
                end
                for (int e = 0; e < v.extra; e++) begin
                    wr_en = 1'b1;
                    wr_data = rand_rec();
                    chk1(nm(fi, "extra_refused"), full_n, 1'b0);
                    @(negedge aclk);
                end
                wr_en = 1'b0;
            end
            begin : restarter
                if (v.restart > 0) begin
                    repeat (v.restart) @(negedge aclk);
                    start = 1'b1;
                    cfg_n = 32'd1;
                    @(negedge aclk);
                    start = 1'b0;
                    cfg_n = v.n;
                end
            end
            begin : monitor
                int mcyc;
                int stall_left;
                mcyc = 0;
                stall_left = v.stall;
                while (!got_done && mcyc < 3000) begin
                    if (done) begin
                        got_done = 1'b1;
                        chki(nm(fi, "done_timing"), mcyc, hs_cyc + 1);
                    end else begin
                        tready = (stall_left == 0);
                        if (stall_left == 1 && v.stall >= 20) begin
                            chk1(nm(fi, "stall_full_n"), full_n, 1'b0);
                            chki(nm(fi, "stall_accepted"), exp_q.size(), (v.n < 8) ? v.n : 8);
                        end
                        if (stall_left > 0) stall_left--;
                        if (tvalid) begin
                            int rem;
                            int filled;
                            logic [511:0] eb;
                            logic [63:0] ek;
                            rem = v.n - rcv;
                            filled = (rem > 4) ? 4 : rem;
                            if (filled <= 0) begin
                                chk1(nm(fi, "beat_unexpected"), tvalid, 1'b0);
                            end else if (exp_q.size() < filled) begin
                                chki(nm(fi, "beat_early"), exp_q.size(), filled);
                            end else begin
                                eb = '0;
                                ek = '0;
                                for (int k = 0; k < filled; k++) begin
                                    eb[k*128 +: 128] = {31'b0, exp_q[k]};
                                    ek[k*16 +: 16] = 16'hFFFF;
                                end
                                chkw(nm(fi, "beat_data"), tdata, eb);
                                chkw(nm(fi, "beat_keep"), 512'(tkeep), 512'(ek));
                                chk1(nm(fi, "beat_last"), tlast, (rcv + filled) == v.n);
                                if (tready) begin
                                    repeat (filled) void'(exp_q.pop_front());
                                    rcv += filled;
                                    beats++;
                                    last_keep = tkeep;
                                    if (rcv == v.n) hs_cyc = mcyc;
                                end
                            end
                        end
                    end
                    @(negedge aclk);
                    mcyc++;
                end
                tready = 1'b1;
            end
        join
        chk1(nm(fi, "done_seen"), got_done, 1'b1);
        chki(nm(fi, "beat_count"), beats, v.exp_beats);
        if (v.exp_beats > 0) begin
            chkw(nm(fi, "last_keep"), 512'(last_keep), 512'(v.exp_last_keep));
        end
        @(negedge aclk);
        chk1(nm(fi, "idle_busy"), busy, 1'b0);
        chk1(nm(fi, "idle_done"), done, 1'b0);
        chk1(nm(fi, "idle_tvalid"), tvalid, 1'b0);
    endtask

    initial begin
        frame_vec_t after_rst;
        //             n   stall extra restart beats last tkeep
        vecs[0] = '{8,  0,  0, 0, 2, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{5,  0,  1, 0, 2, 64'h0000_0000_0000_FFFF};
        vecs[2] = '{12, 30, 0, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{0,  0,  0, 0, 0, 64'h0};
        vecs[4] = '{1,  0,  0, 0, 1, 64'h0000_0000_0000_FFFF};
        vecs[5] = '{7,  0,  2, 0, 2, 64'h0000_FFFF_FFFF_FFFF};
        vecs[6] = '{10, 0,  0, 3, 3, 64'h0000_0000_FFFF_FFFF};
        vecs[7] = '{6,  3,  0, 0, 2, 64'h0000_0000_FFFF_FFFF};
        after_rst = '{4, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF};

        aresetn = 1'b0;
        start = 1'b0;
        cfg_n = '0;
        wr_en = 1'b0;
        wr_data = '0;
        tready = 1'b1;
        repeat (3) @(negedge aclk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk1("reset_full_n", full_n, 1'b0);
        chk1("reset_tvalid", tvalid, 1'b0);
        chk1("reset_tlast", tlast, 1'b0);
        chkw("reset_tdata", tdata, '0);
        chkw("reset_tkeep", 512'(tkeep), '0);
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(i, vecs[i]);
        end

        // Reset in the middle of an n=8 frame after three records.
        @(negedge aclk);
        cfg_n = 32'd8;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = rand_rec();
            @(negedge aclk);
        end
        wr_en = 1'b0;
        repeat (2) @(negedge aclk);
        chk1("pre_rst_busy", busy, 1'b1);
        aresetn = 1'b0;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_full_n", full_n, 1'b0);
        chk1("rst_tvalid", tvalid, 1'b0);
        chk1("rst_tlast", tlast, 1'b0);
        chkw("rst_tdata", tdata, '0);
        chkw("rst_tkeep", 512'(tkeep), '0);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_q.delete();
        run_frame(99, after_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
